// File: rtl/adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_fa_bit.sv
// One-bit full-adder cell producing sum, propagate and carry-out.
module serial_fa_bit (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic p,
    output logic cout
);

    assign p    = a ^ b;
    assign s    = p ^ c;
    assign cout = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: feeds one full-adder cell LSB-first, one bit per clock,
// and presents sum, carry-out, group propagate and signed overflow on a held output port.
module serial_adder_ctrl
    import adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             all_prop,
    output logic             overflow
);

    localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic [WIDTH-2:0] sum_sh;
    logic [CW-1:0]    cnt;
    logic             carry_r, prop_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r, all_prop_r, ovf_r;
    logic             cell_s, cell_p, cell_c;
    logic             last_bit;

    serial_fa_bit u_cell (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .c    (carry_r),
        .s    (cell_s),
        .p    (cell_p),
        .cout (cell_c)
    );

    assign last_bit = (cnt == LAST);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = RUN;
            end
            RUN: begin
                if (last_bit) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Sum bits collect in a working shift register; the visible result only changes on the final bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh       <= '0;
            b_sh       <= '0;
            sum_sh     <= '0;
            cnt        <= '0;
            carry_r    <= 1'b0;
            prop_r     <= 1'b0;
            sum_r      <= '0;
            cout_r     <= 1'b0;
            all_prop_r <= 1'b0;
            ovf_r      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh    <= a;
                        b_sh    <= b;
                        carry_r <= cin;
                        prop_r  <= 1'b1;
                        cnt     <= '0;
                    end
                end
                RUN: begin
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    sum_sh  <= (WIDTH-1)'({cell_s, sum_sh} >> 1);
                    carry_r <= cell_c;
                    prop_r  <= prop_r & cell_p;
                    cnt     <= cnt + CW'(1);
                    if (last_bit) begin
                        sum_r      <= {cell_s, sum_sh};
                        cout_r     <= cell_c;
                        all_prop_r <= prop_r & cell_p;
                        // carry_r is the carry into the MSB on this cycle
                        ovf_r      <= carry_r ^ cell_c;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum      = sum_r;
    assign cout     = cout_r;
    assign all_prop = all_prop_r;
    assign overflow = ovf_r;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: arithmetic reference model compared every cycle,
// plus directed literal cases and randomized operations.
module tb_serial_adder_ctrl;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a, b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout, all_prop, overflow;

    int n_checks = 0;
    int n_fail   = 0;

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .all_prop  (all_prop),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result from plain arithmetic: {overflow, all_prop, cout, sum}.
    function automatic logic [10:0] ref_add(input logic [7:0] x, input logic [7:0] y, input logic c);
        logic [8:0] t;
        logic       ovf;
        t   = {1'b0, x} + {1'b0, y} + {8'd0, c};
        ovf = (x[7] == y[7]) && (t[7] != x[7]);
        return {ovf, &(x ^ y), t};
    endfunction

    // Behavioural model: 0 = waiting for operands, 1 = busy counting bits, 2 = holding a result.
    int         m_phase;
    int         m_left;
    logic [10:0] m_pend;
    logic [10:0] m_res;
    bit         started = 1'b0;

    always @(posedge clk) begin
        started <= 1'b1;
        if (!rst_n) begin
            m_phase <= 0;
            m_left  <= 0;
            m_res   <= '0;
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    m_phase <= 1;
                    m_left  <= WIDTH;
                    m_pend  <= ref_add(a, b, cin);
                end
                1: begin
                    m_left <= m_left - 1;
                    if (m_left == 1) begin
                        m_phase <= 2;
                        m_res   <= m_pend;
                    end
                end
                default: if (out_ready) m_phase <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("in_ready",  in_ready,  m_phase == 0);
            check("out_valid", out_valid, m_phase == 2);
            check("sum",       sum,       m_res[7:0]);
            check("cout",      cout,      m_res[8]);
            check("all_prop",  all_prop,  m_res[9]);
            check("overflow",  overflow,  m_res[10]);
        end
    end

    // Called #1 after a rising edge; returns #1 after the edge where out_valid is first seen.
    task automatic start_op(input logic [7:0] x, input logic [7:0] y, input logic c);
        int n;
        in_valid = 1'b1;
        a        = x;
        b        = y;
        cin      = c;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency", n, WIDTH);
    endtask

    task automatic finish_op(input int hold);
        repeat (hold) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("in_ready_after_handoff", in_ready, 1'b1);
    endtask

    task automatic check_result(input string tag, input logic [7:0] s, input logic co,
                                input logic ap, input logic ov);
        check({tag, "_sum"},      sum,      s);
        check({tag, "_cout"},     cout,     co);
        check({tag, "_all_prop"}, all_prop, ap);
        check({tag, "_overflow"}, overflow, ov);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] held_sum;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready",  in_ready,  1'b1);
        check("reset_out_valid", out_valid, 1'b0);
        check_result("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        start_op(8'h0F, 8'h01, 1'b0);
        check_result("t1", 8'h10, 1'b0, 1'b0, 1'b0);
        finish_op(0);

        start_op(8'hFF, 8'h01, 1'b0);
        check_result("t2", 8'h00, 1'b1, 1'b0, 1'b0);
        finish_op(1);

        start_op(8'h7F, 8'h01, 1'b0);
        check_result("t3", 8'h80, 1'b0, 1'b0, 1'b1);
        finish_op(0);

        start_op(8'hAA, 8'h55, 1'b1);
        check_result("t4", 8'h00, 1'b1, 1'b1, 1'b0);
        finish_op(0);

        // Backpressure with an ignored operand pulse while the result is held.
        start_op(8'h21, 8'h12, 1'b0);
        held_sum = sum;
        check("bp_sum", held_sum, 8'h33);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i == 2);
            a        = 8'hC3;
            b        = 8'h3C;
            @(posedge clk); #1;
            check("bp_in_ready",  in_ready,  1'b0);
            check("bp_out_valid", out_valid, 1'b1);
            check("bp_sum_held",  sum,       held_sum);
        end
        in_valid = 1'b0;
        finish_op(0);
        start_op(8'h03, 8'h04, 1'b0);
        check_result("t5", 8'h07, 1'b0, 1'b0, 1'b0);
        finish_op(0);

        // Reset in the middle of a run aborts it.
        in_valid = 1'b1;
        a        = 8'hFF;
        b        = 8'hFF;
        cin      = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("abort_in_ready",  in_ready,  1'b1);
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_sum",       sum,       8'h00);
        start_op(8'h80, 8'h80, 1'b0);
        check_result("t6", 8'h00, 1'b1, 1'b0, 1'b1);
        finish_op(0);

        // Randomized operations, idle gaps and output backpressure.
        for (int k = 0; k < 40; k++) begin
            logic [7:0]  rx, ry;
            logic        rc;
            logic [10:0] r;
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            rx = 8'($urandom);
            ry = 8'($urandom);
            rc = 1'($urandom);
            r  = ref_add(rx, ry, rc);
            start_op(rx, ry, rc);
            check_result("rand", r[7:0], r[8], r[9], r[10]);
            finish_op($urandom_range(0, 3));
        end

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
